// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// flush length and multiply/divide timeout limit.
package hazard_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MD_BUSY  = 2'd1,
      MEM_WAIT = 2'd2,
      FLUSH    = 2'd3
   } hazard_state_e;

   localparam int unsigned FLUSH_CYCLES  = 2;
   localparam logic [5:0]  MD_TIMEOUT    = 6'd63;
   localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/load_use_detect.sv
// Detects a decode-stage source operand that depends on a load still in execute.
module load_use_detect (
   input  logic       de_valid_i,
   input  logic [4:0] de_rs1addr_i,
   input  logic [4:0] de_rs2addr_i,
   input  logic       de_rs1_used_i,
   input  logic       de_rs2_used_i,
   input  logic       ex_load_i,
   input  logic       ex_wr_reg_i,
   input  logic [4:0] ex_wr_regindex_i,
   output logic       load_use_o
);

   logic exLoadWrites;
   logic rs1Hit;
   logic rs2Hit;

   // x0 is hardwired to zero, so a load targeting it never creates a dependency
   assign exLoadWrites = ex_load_i & ex_wr_reg_i & (ex_wr_regindex_i != 5'd0);
   assign rs1Hit       = de_rs1_used_i & (de_rs1addr_i == ex_wr_regindex_i);
   assign rs2Hit       = de_rs2_used_i & (de_rs2addr_i == ex_wr_regindex_i);
   assign load_use_o   = de_valid_i & exLoadWrites & (rs1Hit | rs2Hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, multiply/divide and memory
// wait stalls, flush sequencing and a saturating stall-cycle counter.
module hazard_ctrl
   import hazard_pkg::*;
(
   input  logic        clk,
   input  logic        cpurst_n,
   input  logic [4:0]  de_rs1addr,
   input  logic [4:0]  de_rs2addr,
   input  logic        de_valid,
   input  logic        de_rs1_used,
   input  logic        de_rs2_used,
   input  logic        ex_load,
   input  logic        ex_wr_reg,
   input  logic [4:0]  ex_wr_regindex,
   input  logic        ex_md_op,
   input  logic        md_done,
   input  logic        mem_req,
   input  logic        mem_ack,
   input  logic        mem2wb_exp_ffout,
   input  logic        interrupt,
   output logic        de_stall,
   output logic        mult_stall,
   output logic        mem_stall,
   output logic        flush,
   output logic        md_kill,
   output logic        md_timeout,
   output logic [15:0] stall_cnt
);

   localparam logic [1:0] FLUSH_LAST = 2'(FLUSH_CYCLES - 1);

   hazard_state_e state_q, state_d;
   logic [5:0]    mdCnt_q, mdCnt_d;
   logic [1:0]    flushCnt_q, flushCnt_d;
   logic          pending_q, pending_d;
   logic [15:0]   stallCnt_q;
   logic          loadUse;
   logic          flushCause;

   assign flushCause = mem2wb_exp_ffout | interrupt;

   load_use_detect u_load_use_detect (
      .de_valid_i       (de_valid),
      .de_rs1addr_i     (de_rs1addr),
      .de_rs2addr_i     (de_rs2addr),
      .de_rs1_used_i    (de_rs1_used),
      .de_rs2_used_i    (de_rs2_used),
      .ex_load_i        (ex_load),
      .ex_wr_reg_i      (ex_wr_reg),
      .ex_wr_regindex_i (ex_wr_regindex),
      .load_use_o       (loadUse)
   );

   always_ff @(posedge clk or negedge cpurst_n) begin
      if (!cpurst_n) begin
         state_q    <= IDLE;
         mdCnt_q    <= '0;
         flushCnt_q <= '0;
         pending_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         mdCnt_q    <= mdCnt_d;
         flushCnt_q <= flushCnt_d;
         pending_q  <= pending_d;
      end
   end

   // A memory access in flight is always allowed to complete; any flush
   // request seen meanwhile is parked in pending_q until the acknowledge.
   always_comb begin
      state_d    = state_q;
      mdCnt_d    = mdCnt_q;
      flushCnt_d = flushCnt_q;
      pending_d  = pending_q;
      unique case (state_q)
         IDLE: begin
            mdCnt_d    = '0;
            flushCnt_d = '0;
            pending_d  = 1'b0;
            if (flushCause)              state_d = FLUSH;
            else if (ex_md_op)           state_d = MD_BUSY;
            else if (mem_req && !mem_ack) state_d = MEM_WAIT;
         end
         MD_BUSY: begin
            if (flushCause) begin
               state_d    = FLUSH;
               flushCnt_d = '0;
            end else if (md_done || mdCnt_q == MD_TIMEOUT) begin
               state_d = IDLE;
            end else begin
               mdCnt_d = mdCnt_q + 6'd1;
            end
         end
         MEM_WAIT: begin
            if (mem_ack) begin
               pending_d  = 1'b0;
               flushCnt_d = '0;
               state_d    = (pending_q || flushCause) ? FLUSH : IDLE;
            end else begin
               pending_d = pending_q | flushCause;
            end
         end
         FLUSH: begin
            if (flushCause)                 flushCnt_d = '0;
            else if (flushCnt_q == FLUSH_LAST) state_d = IDLE;
            else                            flushCnt_d = flushCnt_q + 2'd1;
         end
      endcase
   end

   // A completed multiply/divide result is not killed even when a flush
   // arrives in the same cycle as md_done.
   always_comb begin
      mult_stall = (state_q == MD_BUSY) && !md_done && (mdCnt_q != MD_TIMEOUT);
      md_timeout = (state_q == MD_BUSY) && !md_done && !flushCause && (mdCnt_q == MD_TIMEOUT);
      md_kill    = (state_q == MD_BUSY) && flushCause && !md_done;
      mem_stall  = ((state_q == IDLE) && mem_req && !mem_ack) ||
                   ((state_q == MEM_WAIT) && !mem_ack);
      flush      = (state_q == FLUSH) ||
                   (((state_q == IDLE) || (state_q == MD_BUSY)) && flushCause) ||
                   ((state_q == MEM_WAIT) && mem_ack && (pending_q || flushCause));
      de_stall   = loadUse && !mult_stall && !mem_stall && !flush;
   end

   always_ff @(posedge clk or negedge cpurst_n) begin
      if (!cpurst_n)
         stallCnt_q <= '0;
      else if ((de_stall || mult_stall || mem_stall) && stallCnt_q != STALL_CNT_MAX)
         stallCnt_q <= stallCnt_q + 16'd1;
   end

   assign stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic, every cycle compared against a behavioural model.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        cpurst_n = 1'b1;
   logic [4:0]  de_rs1addr = '0, de_rs2addr = '0, ex_wr_regindex = '0;
   logic        de_valid = 0, de_rs1_used = 0, de_rs2_used = 0;
   logic        ex_load = 0, ex_wr_reg = 0, ex_md_op = 0, md_done = 0;
   logic        mem_req = 0, mem_ack = 0, mem2wb_exp_ffout = 0, interrupt = 0;
   logic        de_stall, mult_stall, mem_stall, flush, md_kill, md_timeout;
   logic [15:0] stall_cnt;

   int checks = 0;
   int failures = 0;

   // behavioural model state: what the controller is currently busy with
   bit mdBusy, memWaiting, memFlushPending;
   int mdAge, flushLeft, stallTotal;
   bit eDe, eMult, eMem, eFlush, eKill, eTo;

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk              (clk),
      .cpurst_n         (cpurst_n),
      .de_rs1addr       (de_rs1addr),
      .de_rs2addr       (de_rs2addr),
      .de_valid         (de_valid),
      .de_rs1_used      (de_rs1_used),
      .de_rs2_used      (de_rs2_used),
      .ex_load          (ex_load),
      .ex_wr_reg        (ex_wr_reg),
      .ex_wr_regindex   (ex_wr_regindex),
      .ex_md_op         (ex_md_op),
      .md_done          (md_done),
      .mem_req          (mem_req),
      .mem_ack          (mem_ack),
      .mem2wb_exp_ffout (mem2wb_exp_ffout),
      .interrupt        (interrupt),
      .de_stall         (de_stall),
      .mult_stall       (mult_stall),
      .mem_stall        (mem_stall),
      .flush            (flush),
      .md_kill          (md_kill),
      .md_timeout       (md_timeout),
      .stall_cnt        (stall_cnt)
   );

   task automatic checkOne(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      mdBusy = 0; memWaiting = 0; memFlushPending = 0;
      mdAge = 0; flushLeft = 0; stallTotal = 0;
   endtask

   task automatic computeModel();
      bit cause;
      bit loadUse;
      cause   = mem2wb_exp_ffout || interrupt;
      loadUse = de_valid && ex_load && ex_wr_reg && (ex_wr_regindex != 0) &&
                ((de_rs1_used && de_rs1addr == ex_wr_regindex) ||
                 (de_rs2_used && de_rs2addr == ex_wr_regindex));
      {eDe, eMult, eMem, eFlush, eKill, eTo} = '0;
      if (flushLeft > 0) begin
         eFlush = 1;
      end else if (mdBusy) begin
         eMult  = !md_done && mdAge < 63;
         eTo    = !md_done && !cause && mdAge == 63;
         eKill  = cause && !md_done;
         eFlush = cause;
      end else if (memWaiting) begin
         eMem   = !mem_ack;
         eFlush = mem_ack && (memFlushPending || cause);
      end else begin
         eMem   = mem_req && !mem_ack;
         eFlush = cause;
      end
      eDe = loadUse && !eMult && !eMem && !eFlush;
   endtask

   task automatic advanceModel();
      bit cause;
      cause = mem2wb_exp_ffout || interrupt;
      if ((eDe || eMult || eMem) && stallTotal < 65535) stallTotal++;
      if (flushLeft > 0) begin
         flushLeft = cause ? 2 : flushLeft - 1;
      end else if (mdBusy) begin
         if (cause) begin
            mdBusy = 0; flushLeft = 2;
         end else if (md_done || mdAge == 63) begin
            mdBusy = 0;
         end else begin
            mdAge++;
         end
      end else if (memWaiting) begin
         if (mem_ack) begin
            memWaiting = 0;
            if (memFlushPending || cause) flushLeft = 2;
            memFlushPending = 0;
         end else begin
            memFlushPending = memFlushPending || cause;
         end
      end else begin
         if (cause) flushLeft = 2;
         else if (ex_md_op) begin mdBusy = 1; mdAge = 0; end
         else if (mem_req && !mem_ack) begin memWaiting = 1; memFlushPending = 0; end
      end
   endtask

   task automatic checkOutput(input string tag);
      #1;
      computeModel();
      checkOne({tag, ".de_stall"},   16'(de_stall),   16'(eDe));
      checkOne({tag, ".mult_stall"}, 16'(mult_stall), 16'(eMult));
      checkOne({tag, ".mem_stall"},  16'(mem_stall),  16'(eMem));
      checkOne({tag, ".flush"},      16'(flush),      16'(eFlush));
      checkOne({tag, ".md_kill"},    16'(md_kill),    16'(eKill));
      checkOne({tag, ".md_timeout"}, 16'(md_timeout), 16'(eTo));
      checkOne({tag, ".stall_cnt"},  stall_cnt,       16'(stallTotal));
   endtask

   task automatic endCycle();
      advanceModel();
      @(negedge clk);
   endtask

   task automatic step(input string tag);
      checkOutput(tag);
      endCycle();
   endtask

   task automatic applyStimulus(input logic mdOp, input logic mdDone, input logic memReq,
                                input logic memAck, input logic exc, input logic intr);
      ex_md_op = mdOp; md_done = mdDone; mem_req = memReq; mem_ack = memAck;
      mem2wb_exp_ffout = exc; interrupt = intr;
   endtask

   task automatic setDecode(input logic valid, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic u1, input logic u2, input logic ld, input logic wr,
                            input logic [4:0] idx);
      de_valid = valid; de_rs1addr = rs1; de_rs2addr = rs2; de_rs1_used = u1;
      de_rs2_used = u2; ex_load = ld; ex_wr_reg = wr; ex_wr_regindex = idx;
   endtask

   // Asserts reset between clock edges and checks outputs before any edge.
   task automatic doReset(input string tag);
      applyStimulus(0, 0, 0, 0, 0, 0);
      cpurst_n = 1'b0;
      modelReset();
      checkOutput(tag);
      checkOne({tag, ".flush0"}, 16'(flush), 16'd0);
      checkOne({tag, ".cnt0"}, stall_cnt, 16'd0);
      @(negedge clk);
      cpurst_n = 1'b1;
   endtask

   initial begin
      #2;
      doReset("reset");

      // load-use on rs2, then the same against x0 and a non-load
      setDecode(1, 5'd3, 5'd5, 0, 1, 1, 1, 5'd5);
      checkOutput("lu_hit");
      checkOne("lu_hit.const", 16'(de_stall), 16'd1);
      endCycle();
      setDecode(1, 5'd0, 5'd0, 0, 1, 1, 1, 5'd0);
      checkOutput("lu_x0");
      checkOne("lu_x0.const", 16'(de_stall), 16'd0);
      endCycle();
      setDecode(1, 5'd5, 5'd0, 1, 0, 0, 1, 5'd5);
      step("lu_noload");
      setDecode(0, 0, 0, 0, 0, 0, 0, 0);

      // multiply/divide completes on the 4th cycle after the start pulse
      applyStimulus(1, 0, 0, 0, 0, 0);
      step("md_start");
      applyStimulus(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("md_busy");
         checkOne("md_busy.const", 16'(mult_stall), 16'd1);
         endCycle();
      end
      applyStimulus(0, 1, 0, 0, 0, 0);
      checkOutput("md_done");
      checkOne("md_done.const", 16'(mult_stall), 16'd0);
      endCycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
      step("md_idle");

      // multiply/divide that never finishes
      applyStimulus(1, 0, 0, 0, 0, 0);
      step("to_start");
      applyStimulus(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 63; i++) step("to_wait");
      checkOutput("to_fire");
      checkOne("to_fire.const", 16'(md_timeout), 16'd1);
      endCycle();
      step("to_after");

      // memory wait with an interrupt parked until the acknowledge
      applyStimulus(0, 0, 1, 0, 0, 0); step("mem_c0");
      applyStimulus(0, 0, 1, 0, 0, 1);
      checkOutput("mem_c1");
      checkOne("mem_c1.noflush", 16'(flush), 16'd0);
      endCycle();
      applyStimulus(0, 0, 1, 0, 0, 0); step("mem_c2");
      applyStimulus(0, 0, 1, 1, 0, 0);
      checkOutput("mem_ack");
      checkOne("mem_ack.flush", 16'(flush), 16'd1);
      endCycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step("mem_flush");

      // exception during multiply/divide kills it
      applyStimulus(1, 0, 0, 0, 0, 0); step("kill_start");
      applyStimulus(0, 0, 0, 0, 0, 0); step("kill_busy");
      applyStimulus(0, 0, 0, 0, 1, 0);
      checkOutput("kill");
      checkOne("kill.const", 16'(md_kill), 16'd1);
      endCycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step("kill_flush");

      // flush coinciding with md_done: no kill
      applyStimulus(1, 0, 0, 0, 0, 0); step("done_start");
      applyStimulus(0, 1, 0, 0, 1, 0);
      checkOutput("done_flush");
      checkOne("done_flush.nokill", 16'(md_kill), 16'd0);
      endCycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step("done_after");

      // restart of the flush count
      applyStimulus(0, 0, 0, 0, 0, 1); step("rs_c0");
      applyStimulus(0, 0, 0, 0, 0, 0); step("rs_c1");
      applyStimulus(0, 0, 0, 0, 0, 1); step("rs_c2");
      applyStimulus(0, 0, 0, 0, 0, 0); step("rs_c3");
      checkOutput("rs_c4");
      checkOne("rs_c4.flush", 16'(flush), 16'd1);
      endCycle();
      step("rs_c5");

      // load-use masked by a memory stall
      setDecode(1, 5'd7, 5'd0, 1, 0, 1, 1, 5'd7);
      applyStimulus(0, 0, 1, 0, 0, 0);
      checkOutput("lu_mem");
      checkOne("lu_mem.const", 16'(de_stall), 16'd0);
      endCycle();
      applyStimulus(0, 0, 1, 1, 0, 0); step("lu_mem_ack");
      setDecode(0, 0, 0, 0, 0, 0, 0, 0);

      // reset while flushing, and while busy in each stall state
      applyStimulus(0, 0, 0, 0, 1, 0); step("rst_fl_cause");
      applyStimulus(0, 0, 0, 0, 0, 0); step("rst_fl_in");
      doReset("rst_flush");
      applyStimulus(1, 0, 0, 0, 0, 0); step("rst_md_start");
      applyStimulus(0, 0, 0, 0, 0, 0); step("rst_md_busy");
      doReset("rst_md");
      step("rst_md_after");
      applyStimulus(0, 0, 1, 0, 0, 0); step("rst_mem_start");
      doReset("rst_mem");
      step("rst_mem_after");

      // randomized traffic with occasional mid-operation resets
      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(0, 299) == 0) begin
            doReset("rand_reset");
         end else begin
            applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                          $urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0);
            setDecode($urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                      5'($urandom_range(0, 3)));
            step("rand");
         end
      end

      // stall counter saturation
      setDecode(0, 0, 0, 0, 0, 0, 0, 0);
      doReset("sat_reset");
      applyStimulus(0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 65540; i++) step("sat");
      checkOutput("sat_end");
      checkOne("sat_end.const", stall_cnt, 16'hFFFF);
      endCycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have port cpurst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports de_rs1addr / de_rs2addr  in  5 each  decode-stage source register indices.
REQ-004 SHALL have ports de_valid, de_rs1_used, de_rs2_used  in  1 each  decode instruction valid and source-operand-used flags.
REQ-005 SHALL have ports ex_load, ex_wr_reg  in  1 each; ex_wr_regindex  in  5  execute-stage load, write-enable and destination register (de_ex register outputs).
REQ-006 SHALL have ports ex_md_op, md_done  in  1 each  multiply/divide start in execute, and completion from the M unit.
REQ-007 SHALL have ports mem_req, mem_ack  in  1 each  data-memory request and acknowledge.
REQ-008 SHALL have ports mem2wb_exp_ffout, interrupt  in  1 each  flush causes.
REQ-009 SHALL have outputs de_stall, mult_stall, mem_stall, flush, md_kill, md_timeout  out  1 each; stall_cnt  out  16.

Function
REQ-010 SHALL implement FSM states IDLE, MD_BUSY, MEM_WAIT, FLUSH.
REQ-011 SHALL raise load_use when de_valid & ex_load & ex_wr_reg & ex_wr_regindex!=0 & ((de_rs1_used & rs1 match) | (de_rs2_used & rs2 match)).
REQ-012 SHALL drive de_stall = load_use & !mult_stall & !mem_stall & !flush, combinationally, same cycle.
REQ-013 IDLE: ex_md_op -> MD_BUSY; otherwise mem_req & !mem_ack -> MEM_WAIT; ex_md_op has priority over mem_req.
REQ-014 mult_stall SHALL be 1 in MD_BUSY while md_done==0, and 0 in the cycle md_done==1; md_done -> IDLE.
REQ-015 SHALL count MD_BUSY cycles in 6-bit counter; at count 63 without md_done, one-cycle md_timeout pulse, mult_stall 0, -> IDLE.
REQ-016 mem_stall SHALL equal (IDLE & mem_req & !mem_ack) | (MEM_WAIT & !mem_ack); mem_ack -> IDLE.
REQ-017 mem2wb_exp_ffout|interrupt in IDLE or MD_BUSY SHALL enter FLUSH next cycle; from MD_BUSY also pulse md_kill one cycle.
REQ-018 Flush cause in MEM_WAIT SHALL be latched as pending; on mem_ack -> FLUSH, never abandoning an in-flight access.
REQ-019 flush SHALL be 1 combinationally in the cause cycle and for exactly 2 further cycles in FLUSH, then -> IDLE.
REQ-020 Flush cause arriving while in FLUSH SHALL restart the 2-cycle count.
REQ-021 md_done and a flush cause in the same MD_BUSY cycle: flush wins, md_kill not pulsed (result complete).
REQ-022 stall_cnt SHALL increment each cycle any of de_stall/mult_stall/mem_stall is 1, saturating at 16'hFFFF.

Reset
REQ-023 cpurst_n low SHALL immediately force state IDLE, counters 0, pending 0, stall_cnt 0; all registered outputs 0.
REQ-024 Reset asserted mid MD_BUSY/MEM_WAIT/FLUSH SHALL abandon the operation with no md_kill or md_timeout pulse.

Structure
REQ-025 State encoding, FLUSH_CYCLES=2, MD_TIMEOUT=63 SHALL reside in shared package hazard_pkg.
REQ-026 Register-match logic of REQ-011 SHALL be sub-module load_use_detect; all else in hazard_ctrl.

Verification
REQ-027 ex_load=1, ex_wr_regindex=5, de_rs2addr=5, de_rs2_used=1 -> de_stall=1 same cycle; same with index 0 -> de_stall=0.
REQ-028 ex_md_op pulse, md_done at 4th cycle -> mult_stall high 3 cycles, IDLE next; no md_done -> md_timeout after 63 cycles.
REQ-029 mem_req with mem_ack delayed 3 cycles, interrupt in cycle 1 -> mem_stall 3 cycles, flush starts on mem_ack, lasts 3 cycles total.
REQ-030 mem2wb_exp_ffout in MD_BUSY -> md_kill 1 cycle, flush 3 cycles, mult_stall 0 from FLUSH entry.
REQ-031 load_use concurrent with mem_stall -> de_stall=0; stall_cnt counts 1 per stalled cycle, holds at FFFF.
REQ-032 cpurst_n low in FLUSH -> flush=0, state IDLE, stall_cnt 0 without waiting for clk.
